// File: rtl/pfw_pkg.sv
// rtl/pfw_pkg.sv - shared types and helpers for the pattern frame writer
//
// Purpose: pattern and FSM state enumerations plus the RGB565 pack helper
// used by every pixel lane of pattern_frame_writer.
package pfw_pkg;

  typedef enum logic [1:0] {
    PAT_SOLID = 2'd0,
    PAT_CROSS = 2'd1,
    PAT_GREY  = 2'd2,
    PAT_RAMP  = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // 8-bit-per-channel colour to RGB565; the low channel bits are truncated.
  function automatic logic [15:0] rgb565(input logic [7:0] r, input logic [7:0] g,
                                         input logic [7:0] b);
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

endpackage

// File: rtl/pfw_pixel_gen.sv
// rtl/pfw_pixel_gen.sv - combinational test-pattern pixel generator (one lane)
//
// Purpose: maps (pattern, x, y) to one RGB565 pixel.
// Ports:
//   sel_in   pattern select
//   x_in     pixel column
//   y_in     pixel row
//   pix_out  RGB565 pixel
module pfw_pixel_gen
  import pfw_pkg::*;
#(
  parameter int HRES = 1280,
  parameter int VRES = 720
) (
  input  pattern_e    sel_in,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  output logic [15:0] pix_out
);

  logic [7:0] w_blue_ramp;

  always_comb begin
    w_blue_ramp = x_in[7:0] + y_in[7:0];
    pix_out     = 16'h0000;
    case (sel_in)
      PAT_SOLID: pix_out = rgb565(8'hFF, 8'h00, 8'hFF);
      PAT_CROSS: pix_out = ((x_in == 16'(HRES / 2)) || (y_in == 16'(VRES / 2))) ?
                           16'hFFFF : 16'h0000;
      PAT_GREY:  pix_out = rgb565(x_in[7:0], x_in[7:0], x_in[7:0]);
      PAT_RAMP:  pix_out = rgb565(x_in[7:0], y_in[7:0], w_blue_ramp);
      default:   pix_out = 16'h0000;
    endcase
  end

endmodule

// File: rtl/pattern_frame_writer.sv
// rtl/pattern_frame_writer.sv - test-pattern frame source for the framebuffer write path
//
// Purpose: emits an HRES x VRES RGB565 frame, PIX_PER_BEAT pixels per beat, on
// independent address/data valid-ready channels. Single-shot or continuous,
// optional double-buffered base, one-cycle frame-done pulse.
// Optional feature macro: PFW_CHECKSUM_EN adds checksum_out (sum of all pixels).
// Ports:
//   clk_in, rst_n_in                 clock, async active-low reset
//   start_in, continuous_in          frame start pulse, auto-restart select
//   pattern_sel_in, base0_in/base1_in  pattern and buffer bases, latched at frame start
//   addr_valid_out/addr_ready_in/addr_out             address channel
//   data_valid_out/data_ready_in/data_out/data_last_out  data channel
//   busy_out, frame_done_out, buf_sel_out            status
//   checksum_out                     frame pixel checksum (PFW_CHECKSUM_EN only)
module pattern_frame_writer
  import pfw_pkg::*;
#(
  parameter int HRES       = 1280,
  parameter int VRES       = 720,
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 27,
  parameter int DOUBLE_BUF = 1
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              start_in,
  input  logic              continuous_in,
  input  logic [1:0]        pattern_sel_in,
  input  logic [ADDR_W-1:0] base0_in,
  input  logic [ADDR_W-1:0] base1_in,
  input  logic              addr_ready_in,
  output logic              addr_valid_out,
  output logic [ADDR_W-1:0] addr_out,
  input  logic              data_ready_in,
  output logic              data_valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic              data_last_out,
  output logic              busy_out,
  output logic              frame_done_out,
  output logic              buf_sel_out
`ifdef PFW_CHECKSUM_EN
  ,
  output logic [31:0]       checksum_out
`endif
);

  localparam int PPB  = DATA_W / 16;
  localparam int BPL  = HRES / PPB;
  localparam int HC_W = (BPL > 1) ? $clog2(BPL) : 1;
  localparam int VC_W = (VRES > 1) ? $clog2(VRES) : 1;
  localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(DATA_W / 8);

  state_e            r_state, w_state_next;
  pattern_e          r_pattern;
  logic [HC_W-1:0]   r_hcount;
  logic [VC_W-1:0]   r_vcount;
  logic [ADDR_W-1:0] r_addr;
  logic              r_addr_valid, r_data_valid, r_buf_sel;
  logic [DATA_W-1:0] w_data;

  logic w_addr_acc, w_data_acc, w_beat_done, w_last_beat, w_enter_run, w_buf_next;

  assign w_addr_acc  = r_addr_valid & addr_ready_in;
  assign w_data_acc  = r_data_valid & data_ready_in;
  // A channel whose valid is already low has been accepted earlier in this beat.
  assign w_beat_done = (r_state == RUN) && (!r_addr_valid || addr_ready_in) &&
                       (!r_data_valid || data_ready_in);
  assign w_last_beat = (r_hcount == HC_W'(BPL - 1)) && (r_vcount == VC_W'(VRES - 1));
  assign w_enter_run = ((r_state == IDLE) && start_in) || ((r_state == DONE) && continuous_in);
  // Buffer toggles on leaving DONE, so a continuous restart must already use the new one.
  assign w_buf_next  = ((r_state == DONE) && (DOUBLE_BUF != 0)) ? ~r_buf_sel : r_buf_sel;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= IDLE;
    else           r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start_in) w_state_next = RUN;
      RUN:     if (w_beat_done && w_last_beat) w_state_next = DONE;
      DONE:    w_state_next = continuous_in ? RUN : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_pattern    <= PAT_SOLID;
      r_hcount     <= '0;
      r_vcount     <= '0;
      r_addr       <= '0;
      r_addr_valid <= 1'b0;
      r_data_valid <= 1'b0;
      r_buf_sel    <= 1'b0;
    end else begin
      r_buf_sel <= w_buf_next;
      if (w_enter_run) begin
        r_pattern    <= pattern_e'(pattern_sel_in);
        r_hcount     <= '0;
        r_vcount     <= '0;
        r_addr       <= w_buf_next ? base1_in : base0_in;
        r_addr_valid <= 1'b1;
        r_data_valid <= 1'b1;
      end else if (r_state == RUN) begin
        if (w_beat_done) begin
          r_addr_valid <= !w_last_beat;
          r_data_valid <= !w_last_beat;
          if (!w_last_beat) begin
            r_addr <= r_addr + BEAT_BYTES;
            if (r_hcount == HC_W'(BPL - 1)) begin
              r_hcount <= '0;
              r_vcount <= r_vcount + 1'b1;
            end else begin
              r_hcount <= r_hcount + 1'b1;
            end
          end
        end else begin
          r_addr_valid <= r_addr_valid & ~w_addr_acc;
          r_data_valid <= r_data_valid & ~w_data_acc;
        end
      end
    end
  end

  for (genvar i = 0; i < PPB; i++) begin : g_lane
    logic [15:0] w_x;
    assign w_x = 16'(r_hcount) * 16'(PPB) + 16'(i);
    pfw_pixel_gen #(.HRES(HRES), .VRES(VRES)) u_pix (
      .sel_in (r_pattern),
      .x_in   (w_x),
      .y_in   (16'(r_vcount)),
      .pix_out(w_data[16*i +: 16])
    );
  end

  assign addr_valid_out = r_addr_valid;
  assign addr_out       = r_addr;
  assign data_valid_out = r_data_valid;
  assign data_out       = (r_state == RUN) ? w_data : '0;
  assign data_last_out  = r_data_valid && w_last_beat;
  assign busy_out       = (r_state == RUN);
  assign frame_done_out = (r_state == DONE);
  assign buf_sel_out    = r_buf_sel;

`ifdef PFW_CHECKSUM_EN
  logic [31:0] w_beat_sum, r_sum;

  always_comb begin
    w_beat_sum = '0;
    for (int i = 0; i < PPB; i++) w_beat_sum = w_beat_sum + 32'(w_data[16*i +: 16]);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_sum        <= '0;
      checksum_out <= '0;
    end else begin
      if (w_enter_run)     r_sum <= '0;
      else if (w_data_acc) r_sum <= r_sum + w_beat_sum;
      if (r_state == DONE) checksum_out <= r_sum;
    end
  end
`else
  // Default build carries no checksum accumulator.
`endif

endmodule
